instr_encoder: RTL and testbench

- Streaming instruction encoder: accepts field-level instruction requests and emits packed 32-bit instruction words plus sequential IMEM write addresses.
- Used by the program loader/testbench front end to fill instruction memory.
- Output words round-trip exactly through the core's instruction decode.
- Seals the stream after a HALT until `restart`.

---
 rtl/instr_pkg.sv | 95 +++++++++
 rtl/instr_encoder_if.sv | 41 ++++
 rtl/instr_enc_fifo2.sv | 52 +++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Encoding constants, request record and word-packing helper for the instruction encoder.
package instr_pkg;

    typedef enum logic [2:0] {
        KindAluImm = 3'd0,
        KindAluReg = 3'd1,
        KindLoad   = 3'd2,
        KindStore  = 3'd3,
        KindBranch = 3'd4,
        KindHalt   = 3'd5,
        KindNop    = 3'd6,
        KindRsvd   = 3'd7
    } kindE;

    localparam logic [1:0] ClassAluImm = 2'b00;
    localparam logic [1:0] ClassAluReg = 2'b01;
    localparam logic [1:0] ClassMem    = 2'b10;
    localparam logic [1:0] ClassCtrl   = 2'b11;

    localparam logic [31:0] HaltWord = 32'hD000_0000;
    localparam logic [31:0] NopWord  = 32'hC800_0000;

    localparam int unsigned ClassHi     = 31;
    localparam int unsigned ClassLo     = 30;
    localparam int unsigned AluModeBit  = 29;
    localparam int unsigned SetFlagsBit = 28;
    localparam int unsigned FuncHi      = 27;
    localparam int unsigned FuncLo      = 25;
    localparam int unsigned LdstRegBit  = 26;
    localparam int unsigned StoreBit    = 25;
    localparam int unsigned CondEnBit   = 26;
    localparam int unsigned CondHi      = 24;
    localparam int unsigned CondLo      = 21;
    localparam int unsigned RdHi        = 24;
    localparam int unsigned RdLo        = 22;
    localparam int unsigned Rs1Hi       = 21;
    localparam int unsigned Rs1Lo       = 19;
    localparam int unsigned Rs2Hi       = 18;
    localparam int unsigned Rs2Lo       = 16;
    localparam int unsigned ImmHi       = 15;
    localparam int unsigned ImmLo       = 0;

    typedef struct packed {
        kindE        kind;
        logic        aluMode;
        logic        setFlags;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic        condEn;
        logic [3:0]  cond;
        logic        ldstReg;
    } reqT;

    // Register and immediate fields pass through for every field-carrying kind;
    // a branch condition then overlays the rd/rs1 bits it shares.
    function automatic logic [31:0] encodeWord(reqT req);
        logic [31:0] w;
        w = '0;
        w[RdHi:RdLo]   = req.rd;
        w[Rs1Hi:Rs1Lo] = req.rs1;
        w[Rs2Hi:Rs2Lo] = req.rs2;
        w[ImmHi:ImmLo] = req.imm;
        case (req.kind)
            KindAluImm: begin
                w[ClassHi:ClassLo] = ClassAluImm;
                w[AluModeBit]      = req.aluMode;
                w[SetFlagsBit]     = req.setFlags;
                w[FuncHi:FuncLo]   = req.func;
            end
            KindAluReg: begin
                w[ClassHi:ClassLo] = ClassAluReg;
                w[AluModeBit]      = req.aluMode;
                w[FuncHi:FuncLo]   = req.func;
            end
            KindLoad, KindStore: begin
                w[ClassHi:ClassLo] = ClassMem;
                w[LdstRegBit]      = req.ldstReg;
                w[StoreBit]        = (req.kind == KindStore);
            end
            KindBranch: begin
                w[ClassHi:ClassLo] = ClassCtrl;
                w[CondEnBit]       = req.condEn;
                w[CondHi:CondLo]   = req.condEn ? req.cond : 4'h0;
            end
            KindHalt: w = HaltWord;
            KindNop:  w = NopWord;
            default:  w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and output-stream bundle of the instruction encoder; slave is the encoder side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
);

    logic              restart;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic              in_alu_mode;
    logic              in_set_flags;
    logic [2:0]        in_func;
    logic [2:0]        in_rd;
    logic [2:0]        in_rs1;
    logic [2:0]        in_rs2;
    logic [15:0]       in_imm;
    logic              in_cond_en;
    logic [3:0]        in_cond;
    logic              in_ldst_reg;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              sealed;
    logic [CNT_W-1:0]  word_count;
    logic              err;

    modport slave (
        input  restart, in_valid, in_kind, in_alu_mode, in_set_flags, in_func,
               in_rd, in_rs1, in_rs2, in_imm, in_cond_en, in_cond, in_ldst_reg, out_ready,
        output in_ready, out_valid, out_word, out_addr, sealed, word_count, err
    );

    modport master (
        output restart, in_valid, in_kind, in_alu_mode, in_set_flags, in_func,
               in_rd, in_rs1, in_rs2, in_imm, in_cond_en, in_cond, in_ldst_reg, out_ready,
        input  in_ready, out_valid, out_word, out_addr, sealed, word_count, err
    );

endinterface

// File: rtl/instr_enc_fifo2.sv
// Two-entry valid/ready skid buffer with synchronous flush; head entry is held until popped.
module instr_enc_fifo2 #(
    parameter int unsigned Width = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             pushValid,
    input  logic [Width-1:0] pushData,
    output logic             full,
    output logic             popValid,
    input  logic             popReady,
    output logic [Width-1:0] popData
);

    logic [Width-1:0] memQ [2];
    logic             wrPtrQ;
    logic             rdPtrQ;
    logic [1:0]       countQ;
    logic             doPush;
    logic             doPop;

    assign full     = (countQ == 2'd2);
    assign popValid = (countQ != 2'd0);
    assign popData  = memQ[rdPtrQ];
    assign doPush   = pushValid & ~full;
    assign doPop    = popValid & popReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memQ[0] <= '0;
            memQ[1] <= '0;
            wrPtrQ  <= 1'b0;
            rdPtrQ  <= 1'b0;
            countQ  <= 2'd0;
        end else if (flush) begin
            wrPtrQ <= 1'b0;
            rdPtrQ <= 1'b0;
            countQ <= 2'd0;
        end else begin
            if (doPush) begin
                memQ[wrPtrQ] <= pushData;
                wrPtrQ       <= ~wrPtrQ;
            end
            if (doPop) begin
                rdPtrQ <= ~rdPtrQ;
            end
            countQ <= countQ + {1'b0, doPush} - {1'b0, doPop};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs field requests into IMEM words with sequential addresses.
// Define INSTR_ENC_CHECK_EN to also reject field combinations the decoder would misread.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input logic           clk,
    input logic           rst,
    instr_encoder_if.slave bus
);

    localparam int unsigned DataW = 32 + ADDR_W;
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

    typedef enum logic [0:0] {
        StRun,
        StSealed
    } stateE;

    stateE             stateQ;
    logic [ADDR_W-1:0] addrQ;
    logic [CNT_W-1:0]  countQ;
    logic              sealedQ;
    logic              errQ;

    reqT               req;
    logic              legal;
    logic              accept;
    logic              push;
    logic              full;
    logic              popValid;
    logic              handshake;
    logic [DataW-1:0]  headData;
    logic [31:0]       headWord;

    always_comb begin
        req          = '0;
        req.kind     = kindE'(bus.in_kind);
        req.aluMode  = bus.in_alu_mode;
        req.setFlags = bus.in_set_flags;
        req.func     = bus.in_func;
        req.rd       = bus.in_rd;
        req.rs1      = bus.in_rs1;
        req.rs2      = bus.in_rs2;
        req.imm      = bus.in_imm;
        req.condEn   = bus.in_cond_en;
        req.cond     = bus.in_cond;
        req.ldstReg  = bus.in_ldst_reg;
    end

    always_comb begin
        legal = (req.kind != KindRsvd);
`ifdef INSTR_ENC_CHECK_EN
        case (req.kind)
            KindAluImm: if (req.setFlags && !req.aluMode) legal = 1'b0;
            // func[2:1]==00 on a register op would decode as the immediate form
            KindAluReg: if (req.setFlags || req.func[2:1] == 2'b00) legal = 1'b0;
            KindBranch: if (!req.condEn && req.cond != 4'h0) legal = 1'b0;
            default: ;
        endcase
`endif
    end

    assign bus.in_ready = ~rst & ~full & (stateQ == StRun);
    assign accept       = bus.in_valid & bus.in_ready & ~bus.restart;
    assign push         = accept & legal;
    assign handshake    = popValid & bus.out_ready & ~bus.restart;
    assign headWord     = headData[DataW-1:ADDR_W];

    instr_enc_fifo2 #(
        .Width(DataW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.restart),
        .pushValid(push),
        .pushData ({encodeWord(req), addrQ}),
        .full     (full),
        .popValid (popValid),
        .popReady (bus.out_ready),
        .popData  (headData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StRun;
            addrQ   <= '0;
            countQ  <= '0;
            sealedQ <= 1'b0;
            errQ    <= 1'b0;
        end else if (bus.restart) begin
            stateQ  <= StRun;
            addrQ   <= '0;
            countQ  <= '0;
            sealedQ <= 1'b0;
            errQ    <= 1'b0;
        end else begin
            errQ <= accept & ~legal;
            if (push) begin
                addrQ <= addrQ + AddrOne;
                if (req.kind == KindHalt) begin
                    stateQ <= StSealed;
                end
            end
            if (handshake) begin
                if (countQ != '1) begin
                    countQ <= countQ + CntOne;
                end
                // Only HALT can produce this word, so it marks the seal point in the stream
                if (headWord == HaltWord) begin
                    sealedQ <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = popValid;
    assign bus.out_word   = headWord;
    assign bus.out_addr   = headData[ADDR_W-1:0];
    assign bus.sealed     = sealedQ;
    assign bus.word_count = countQ;
    assign bus.err        = errQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed vectors, throughput/wrap run, random backpressure
// against a queue model, HALT sealing, restart and reset corner cases.
module tb_instr_encoder;

    localparam int unsigned AddrW = 8;
    localparam int unsigned CntW  = 16;
`ifdef INSTR_ENC_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  kind;
        logic        aluMode;
        logic        setFlags;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic        condEn;
        logic [3:0]  cond;
        logic        ldstReg;
    } reqT;

    typedef struct {
        reqT         req;
        logic [31:0] word;
        bit          reject;
    } vecT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passCnt = 0;
    int   totalCnt = 0;

    instr_encoder_if #(.ADDR_W(AddrW), .CNT_W(CntW)) bus ();

    instr_encoder #(.ADDR_W(AddrW), .CNT_W(CntW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic reqT mkReq(input logic [2:0] kind, input logic mode, input logic setF,
                                  input logic [2:0] func, input logic [2:0] rd,
                                  input logic [2:0] rs1, input logic [2:0] rs2,
                                  input logic [15:0] imm, input logic condEn,
                                  input logic [3:0] cond, input logic ldst);
        reqT r;
        r.kind = kind; r.aluMode = mode; r.setFlags = setF; r.func = func;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        r.condEn = condEn; r.cond = cond; r.ldstReg = ldst;
        return r;
    endfunction

    // Reference encoding written directly from the field layout of each instruction class.
    function automatic logic [31:0] refWord(input reqT r);
        case (r.kind)
            3'd0: return {2'b00, r.aluMode, r.setFlags, r.func, r.rd, r.rs1, r.rs2, r.imm};
            3'd1: return {2'b01, r.aluMode, 1'b0, r.func, r.rd, r.rs1, r.rs2, r.imm};
            3'd2, 3'd3: return {2'b10, 3'b000, r.ldstReg, r.kind == 3'd3, r.rd, r.rs1, r.rs2, r.imm};
            3'd4: return {2'b11, 3'b000, r.condEn, 1'b0, (r.condEn ? r.cond : 4'h0),
                          r.rs1[1:0], r.rs2, r.imm};
            3'd5: return 32'hD000_0000;
            3'd6: return 32'hC800_0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit refLegal(input reqT r);
        if (r.kind == 3'd7) return 1'b0;
        if (ChkEn) begin
            if (r.kind == 3'd0 && r.setFlags && !r.aluMode) return 1'b0;
            if (r.kind == 3'd1 && (r.setFlags || r.func[2:1] == 2'b00)) return 1'b0;
            if (r.kind == 3'd4 && !r.condEn && r.cond != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic driveReq(input reqT r);
        bus.in_kind = r.kind; bus.in_alu_mode = r.aluMode; bus.in_set_flags = r.setFlags;
        bus.in_func = r.func; bus.in_rd = r.rd; bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2;
        bus.in_imm = r.imm; bus.in_cond_en = r.condEn; bus.in_cond = r.cond;
        bus.in_ldst_reg = r.ldstReg;
    endtask

    task automatic pulseRestart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    vecT               vecs[$];
    reqT               nopReq;
    reqT               rr;
    logic [31:0]       qWord[$];
    logic [AddrW-1:0]  qAddr[$];
    logic [AddrW-1:0]  expAddr;
    int                expCnt;

    initial begin
        bus.restart = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        nopReq = mkReq(3'd6, 1'b1, 1'b1, 3'd7, 3'd5, 3'd3, 3'd1, 16'h1234, 1'b1, 4'hF, 1'b1);
        driveReq(nopReq);

        // Reset state, sampled while reset is held
        tick(); tick();
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_word", bus.out_word, 32'd0);
        check("rst out_addr", 32'(bus.out_addr), 32'd0);
        check("rst sealed", 32'(bus.sealed), 32'd0);
        check("rst word_count", 32'(bus.word_count), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

        // Fixed vectors, one request per cycle with the consumer always ready
        vecs.push_back('{mkReq(3'd0, 1, 1, 3'b010, 3'd1, 3'd2, 3'd0, 16'h0005, 0, 4'h0, 0),
                         32'h3450_0005, 1'b0});
        vecs.push_back('{mkReq(3'd3, 0, 0, 3'd0, 3'd3, 3'd4, 3'd0, 16'h0010, 0, 4'h0, 0),
                         32'h82E0_0010, 1'b0});
        vecs.push_back('{mkReq(3'd4, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1, 4'b0011, 0),
                         32'hC460_0000, 1'b0});
        vecs.push_back('{nopReq, 32'hC800_0000, 1'b0});
        vecs.push_back('{mkReq(3'd2, 1, 1, 3'd7, 3'd7, 3'd1, 3'd2, 16'hBEEF, 1, 4'h9, 1),
                         32'h85CA_BEEF, 1'b0});
        vecs.push_back('{mkReq(3'd1, 0, 0, 3'b001, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 4'h0, 0),
                         32'h4200_0000, ChkEn});
        vecs.push_back('{mkReq(3'd7, 1, 1, 3'd3, 3'd3, 3'd3, 3'd3, 16'h5555, 1, 4'h3, 1),
                         32'h0000_0000, 1'b1});
        vecs.push_back('{mkReq(3'd4, 1, 1, 3'd7, 3'd2, 3'd3, 3'd1, 16'h00FF, 0, 4'h5, 1),
                         32'hC019_00FF, ChkEn});
        vecs.push_back('{mkReq(3'd0, 0, 1, 3'd7, 3'd0, 3'd0, 3'd7, 16'hFFFF, 0, 4'h0, 0),
                         32'h1E07_FFFF, ChkEn});
        vecs.push_back('{mkReq(3'd1, 1, 1, 3'd5, 3'd6, 3'd5, 3'd4, 16'h8001, 0, 4'h0, 0),
                         32'h6BAC_8001, ChkEn});
        expAddr = '0;
        expCnt = 0;
        foreach (vecs[i]) begin
            driveReq(vecs[i].req);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            if (vecs[i].reject) begin
                check($sformatf("vec%0d err", i), 32'(bus.err), 32'd1);
                check($sformatf("vec%0d no word", i), 32'(bus.out_valid), 32'd0);
            end else begin
                check($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'd1);
                check($sformatf("vec%0d word", i), bus.out_word, vecs[i].word);
                check($sformatf("vec%0d addr", i), 32'(bus.out_addr), 32'(expAddr));
                check($sformatf("vec%0d err", i), 32'(bus.err), 32'd0);
                expAddr++;
                expCnt++;
            end
        end
        tick();
        check("vec word_count", 32'(bus.word_count), 32'(expCnt));
        check("vec err cleared", 32'(bus.err), 32'd0);

        // Restart beats a same-cycle accept
        driveReq(nopReq);
        bus.in_valid = 1'b1;
        pulseRestart();
        bus.in_valid = 1'b0;
        tick();
        check("restart drops accept", 32'(bus.out_valid), 32'd0);
        check("restart word_count", 32'(bus.word_count), 32'd0);

        // 300 back-to-back NOPs: full rate and address wrap
        begin
            int accepted = 0, seen = 0, stalls = 0, bad = 0, firstC = -1, lastC = 0;
            logic [AddrW-1:0] a = '0;
            logic [AddrW-1:0] lastAddr = '0;
            bus.in_valid = 1'b1;
            for (int c = 0; c < 400 && seen < 300; c++) begin
                @(negedge clk);
                if (bus.in_valid && bus.in_ready) accepted++;
                else if (bus.in_valid) stalls++;
                if (bus.out_valid) begin
                    if (bus.out_word !== 32'hC800_0000 || bus.out_addr !== a) bad++;
                    if (firstC < 0) firstC = c;
                    lastC = c;
                    lastAddr = bus.out_addr;
                    a++;
                    seen++;
                end
                if (accepted == 300 && bus.in_valid) begin
                    @(posedge clk);
                    #1;
                    bus.in_valid = 1'b0;
                end
            end
            tick();
            check("nop accepted", 32'(accepted), 32'd300);
            check("nop words seen", 32'(seen), 32'd300);
            check("nop in_ready stalls", 32'(stalls), 32'd0);
            check("nop bad word/addr", 32'(bad), 32'd0);
            check("nop rate", 32'(lastC - firstC), 32'd299);
            check("nop last addr", 32'(lastAddr), 32'd43);
            check("nop word_count", 32'(bus.word_count), 32'd300);
        end

        // Random requests under random backpressure against a queue model
        pulseRestart();
        begin
            bit pending = 0, errNext = 0, holdValid = 0, done = 0;
            int sent = 0;
            logic [31:0] holdWord;
            logic [AddrW-1:0] holdAddr;
            expAddr = '0;
            expCnt = 0;
            for (int c = 0; c < 3000 && !done; c++) begin
                tick();
                if (errNext) check("rand err pulse", 32'(bus.err), 32'd1);
                errNext = 0;
                bus.out_ready = 1'($urandom_range(0, 1));
                if (!pending) begin
                    if (sent < 50) begin
                        rr = mkReq(3'($urandom_range(0, 6)), 1'($urandom), 1'($urandom),
                                   3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                                   16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
                        if (rr.kind == 3'd5) rr.kind = 3'd7;
                        driveReq(rr);
                        bus.in_valid = 1'b1;
                        pending = 1;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                if (holdValid) begin
                    check("rand hold valid", 32'(bus.out_valid), 32'd1);
                    check("rand hold word", bus.out_word, holdWord);
                    check("rand hold addr", 32'(bus.out_addr), 32'(holdAddr));
                end
                if (bus.in_valid && !bus.in_ready)
                    check("rand in_ready low only when 2 held", 32'(qWord.size()), 32'd2);
                if (bus.out_valid && bus.out_ready) begin
                    if (qWord.size() == 0) begin
                        check("rand unexpected word", bus.out_word, 32'hFFFF_FFFF);
                    end else begin
                        check("rand word", bus.out_word, qWord.pop_front());
                        check("rand addr", 32'(bus.out_addr), 32'(qAddr.pop_front()));
                        expCnt++;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (refLegal(rr)) begin
                        qWord.push_back(refWord(rr));
                        qAddr.push_back(expAddr);
                        expAddr++;
                    end else begin
                        errNext = 1;
                    end
                    pending = 0;
                    sent++;
                end
                holdValid = bus.out_valid && !bus.out_ready;
                holdWord = bus.out_word;
                holdAddr = bus.out_addr;
                done = (sent == 50) && !pending && (qWord.size() == 0);
            end
            check("rand drained in budget", 32'(done), 32'd1);
            bus.in_valid = 1'b0;
            tick();
            if (errNext) check("rand final err pulse", 32'(bus.err), 32'd1);
            check("rand word_count", 32'(bus.word_count), 32'(expCnt));
            check("rand no leftover", 32'(bus.out_valid), 32'd0);
        end

        // HALT seals the stream; restart reopens it
        bus.out_ready = 1'b1;
        driveReq(mkReq(3'd5, 1, 1, 3'd7, 3'd7, 3'd7, 3'd7, 16'hFFFF, 1, 4'hF, 1));
        bus.in_valid = 1'b1;
        tick();
        driveReq(nopReq);
        check("halt in_ready", 32'(bus.in_ready), 32'd0);
        check("halt word", bus.out_word, 32'hD000_0000);
        check("halt addr", 32'(bus.out_addr), 32'(expAddr));
        check("halt sealed before handshake", 32'(bus.sealed), 32'd0);
        tick();
        check("halt sealed", 32'(bus.sealed), 32'd1);
        check("halt word_count", 32'(bus.word_count), 32'(expCnt + 1));
        tick();
        check("sealed blocks nop", 32'(bus.out_valid), 32'd0);
        check("sealed in_ready", 32'(bus.in_ready), 32'd0);
        pulseRestart();
        check("restart sealed", 32'(bus.sealed), 32'd0);
        check("restart word_count", 32'(bus.word_count), 32'd0);
        check("restart in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("restart nop word", bus.out_word, 32'hC800_0000);
        check("restart nop addr", 32'(bus.out_addr), 32'd0);
        tick();

        // Two held entries stall the input and freeze the head, then reset discards them
        pulseRestart();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("full in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("full head word", bus.out_word, 32'hC800_0000);
        check("full head addr", 32'(bus.out_addr), 32'd0);
        rst = 1'b1;
        #2;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("post midrst word_count", 32'(bus.word_count), 32'd0);
        check("post midrst in_ready", 32'(bus.in_ready), 32'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
